// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: bus-programmed fade sequencer mastering the PWM bank write port.
// Define PWM_FADE_IRQ_EN to add the CTRL[3] interrupt enable and drive irq_o.
module pwm_fade_ctrl #(
   parameter int BusWidth   = 32,
   parameter int PwmCtrSize = 8,
   parameter int IdxWidth   = 7
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                device_req_i,
   input  logic [BusWidth-1:0] device_addr_i,
   input  logic                device_we_i,
   input  logic [3:0]          device_be_i,
   input  logic [BusWidth-1:0] device_wdata_i,
   output logic                device_rvalid_o,
   output logic [BusWidth-1:0] device_rdata_o,
   output logic                pwm_req_o,
   output logic [BusWidth-1:0] pwm_addr_o,
   output logic                pwm_we_o,
   output logic [3:0]          pwm_be_o,
   output logic [BusWidth-1:0] pwm_wdata_o,
   input  logic                pwm_rvalid_i,
   output logic                irq_o
);

   localparam int P = PwmCtrSize;

   typedef enum logic [2:0] {
      IDLE,
      WR_CTR,
      WR_PW,
      DWELL,
      DONE
   } state_e;

   state_e state_q, state_d;

   logic [2:0] reg_sel;
   logic       wr_en;
   logic       sel_ctrl, sel_chan, sel_lvl, sel_tim, sel_stat;
   logic       start_pulse, abort_pulse, start_acc;
   logic       busy;

   logic                loop_q;
   logic                irq_en_rd;
   logic [IdxWidth-1:0] chan_q;
   logic [P-1:0]        lv_start_q, lv_end_q, lv_max_q;
   logic [P-1:0]        step_q;
   logic [15:0]         dwell_q;
   logic                done_q;

   logic [IdxWidth-1:0] sh_idx_q;
   logic [P-1:0]        sh_max_q, sh_step_q;
   logic [15:0]         sh_dwell_q;

   logic [P-1:0] cur_q, cur_d, tgt_q, tgt_d, src_q, src_d;
   logic         dir_q, dir_d;
   logic [15:0]  cnt_q, cnt_d;
   logic         issued_q, issued_d;
   logic         abort_q, abort_d;
   logic         done_set;
   logic         pwm_req;

   logic [P:0]   up_sum, dn_diff;
   logic [P-1:0] next_lvl;

   logic                rvalid_q;
   logic [BusWidth-1:0] rdata_q, rd_mux;
   logic [BusWidth-1:0] pwm_addr, pwm_wdata;

   logic unused_bus;

   assign unused_bus = ^{device_be_i, device_addr_i, device_wdata_i};

   assign reg_sel  = device_addr_i[4:2];
   assign wr_en    = device_req_i & device_we_i;
   assign sel_ctrl = (reg_sel == 3'd0);
   assign sel_chan = (reg_sel == 3'd1);
   assign sel_lvl  = (reg_sel == 3'd2);
   assign sel_tim  = (reg_sel == 3'd3);
   assign sel_stat = (reg_sel == 3'd4);

   assign start_pulse = wr_en & sel_ctrl & device_wdata_i[0];
   assign abort_pulse = wr_en & sel_ctrl & device_wdata_i[1];
   assign busy        = (state_q != IDLE);
   assign start_acc   = start_pulse & ~abort_pulse & ~busy;

`ifdef PWM_FADE_IRQ_EN
   logic irq_en_q;

   // Interrupt enable bit, software writable through CTRL[3]
   always_ff @(posedge clk_i) begin
      if (rst_i) irq_en_q <= 1'b0;
      else if (wr_en & sel_ctrl) irq_en_q <= device_wdata_i[3];
   end

   assign irq_en_rd = irq_en_q;
   assign irq_o     = done_q & irq_en_q;
`else
   assign irq_en_rd = 1'b0;
   assign irq_o     = 1'b0;
`endif

   // Software-visible registers and the sticky DONE flag
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         loop_q     <= 1'b0;
         chan_q     <= '0;
         lv_start_q <= '0;
         lv_end_q   <= '0;
         lv_max_q   <= '0;
         step_q     <= '0;
         dwell_q    <= '0;
         done_q     <= 1'b0;
      end else begin
         if (wr_en & sel_ctrl) loop_q <= device_wdata_i[2];
         if (wr_en & sel_chan) chan_q <= device_wdata_i[IdxWidth-1:0];
         if (wr_en & sel_lvl) begin
            lv_start_q <= device_wdata_i[P-1:0];
            lv_end_q   <= device_wdata_i[2*P-1:P];
            lv_max_q   <= device_wdata_i[3*P-1:2*P];
         end
         if (wr_en & sel_tim) begin
            step_q  <= device_wdata_i[P-1:0];
            dwell_q <= device_wdata_i[31:16];
         end
         if (done_set) done_q <= 1'b1;
         else if (wr_en & sel_stat & device_wdata_i[1]) done_q <= 1'b0;
      end
   end

   // Register read mux; unmapped offsets fall through to zero
   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         3'd0: begin
            rd_mux[2] = loop_q;
            rd_mux[3] = irq_en_rd;
         end
         3'd1: rd_mux[IdxWidth-1:0] = chan_q;
         3'd2: begin
            rd_mux[P-1:0]     = lv_start_q;
            rd_mux[2*P-1:P]   = lv_end_q;
            rd_mux[3*P-1:2*P] = lv_max_q;
         end
         3'd3: begin
            rd_mux[P-1:0] = step_q;
            rd_mux[31:16] = dwell_q;
         end
         3'd4: begin
            rd_mux[0] = busy;
            rd_mux[1] = done_q;
         end
         default: rd_mux = '0;
      endcase
   end

   // Slave response: one cycle after every request
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= device_req_i;
         rdata_q  <= (device_req_i & ~device_we_i) ? rd_mux : '0;
      end
   end

   assign device_rvalid_o = rvalid_q;
   assign device_rdata_o  = rdata_q;

   // Shadow copies frozen at START so software may rewrite mid-fade
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sh_idx_q   <= '0;
         sh_max_q   <= '0;
         sh_step_q  <= '0;
         sh_dwell_q <= '0;
      end else if (start_acc) begin
         sh_idx_q   <= chan_q;
         sh_max_q   <= lv_max_q;
         sh_step_q  <= (step_q == '0) ? P'(1) : step_q;
         sh_dwell_q <= (dwell_q == '0) ? 16'd1 : dwell_q;
      end
   end

   // Next level one step toward the target, clamped so it never passes it
   always_comb begin
      up_sum  = {1'b0, cur_q} + {1'b0, sh_step_q};
      dn_diff = {1'b0, cur_q} - {1'b0, sh_step_q};
      if (dir_q) begin
         if (up_sum >= {1'b0, tgt_q}) next_lvl = tgt_q;
         else next_lvl = up_sum[P-1:0];
      end else begin
         if (dn_diff[P] || (dn_diff[P-1:0] <= tgt_q)) next_lvl = tgt_q;
         else next_lvl = dn_diff[P-1:0];
      end
   end

   // FSM state and datapath registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cur_q    <= '0;
         tgt_q    <= '0;
         src_q    <= '0;
         dir_q    <= 1'b0;
         cnt_q    <= '0;
         issued_q <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         tgt_q    <= tgt_d;
         src_q    <= src_d;
         dir_q    <= dir_d;
         cnt_q    <= cnt_d;
         issued_q <= issued_d;
         abort_q  <= abort_d;
      end
   end

   // FSM next state; abort drains an outstanding request before idling
   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      tgt_d    = tgt_q;
      src_d    = src_q;
      dir_d    = dir_q;
      cnt_d    = cnt_q;
      issued_d = issued_q;
      abort_d  = abort_q;
      done_set = 1'b0;
      pwm_req  = 1'b0;
      if (busy && (abort_pulse || abort_q)) begin
         if (issued_q && !pwm_rvalid_i) begin
            abort_d = 1'b1;
         end else begin
            state_d  = IDLE;
            issued_d = 1'b0;
            abort_d  = 1'b0;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_acc) begin
                  state_d  = WR_CTR;
                  cur_d    = lv_start_q;
                  tgt_d    = lv_end_q;
                  src_d    = lv_start_q;
                  dir_d    = (lv_end_q >= lv_start_q);
                  issued_d = 1'b0;
               end
            end
            WR_CTR, WR_PW: begin
               if (!issued_q) begin
                  pwm_req  = 1'b1;
                  issued_d = 1'b1;
               end else if (pwm_rvalid_i) begin
                  issued_d = 1'b0;
                  if (state_q == WR_CTR) begin
                     state_d = WR_PW;
                  end else if (cur_q == tgt_q) begin
                     state_d = DONE;
                  end else begin
                     state_d = DWELL;
                     cnt_d   = '0;
                  end
               end
            end
            DWELL: begin
               if (cnt_q == sh_dwell_q - 16'd1) begin
                  cur_d   = next_lvl;
                  state_d = WR_PW;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            DONE: begin
               done_set = 1'b1;
               if (loop_q) begin
                  tgt_d   = src_q;
                  src_d   = tgt_q;
                  dir_d   = ~dir_q;
                  cnt_d   = '0;
                  state_d = DWELL;
               end else begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // PWM write address/data for the current request
   always_comb begin
      pwm_addr  = '0;
      pwm_wdata = '0;
      pwm_addr[IdxWidth+2:3] = sh_idx_q;
      pwm_addr[2]            = (state_q == WR_CTR);
      pwm_wdata[P-1:0] = (state_q == WR_CTR) ? sh_max_q : cur_q;
   end

   assign pwm_req_o   = pwm_req;
   assign pwm_we_o    = pwm_req;
   assign pwm_be_o    = pwm_req ? 4'hF : 4'h0;
   assign pwm_addr_o  = pwm_req ? pwm_addr : '0;
   assign pwm_wdata_o = pwm_req ? pwm_wdata : '0;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl: directed bench for pwm_fade_ctrl with a PWM bank responder.
// Build with or without PWM_FADE_IRQ_EN; expectations follow the macro.
module tb_pwm_fade_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        device_req_i;
   logic [31:0] device_addr_i;
   logic        device_we_i;
   logic [3:0]  device_be_i;
   logic [31:0] device_wdata_i;
   logic        device_rvalid_o;
   logic [31:0] device_rdata_o;
   logic        pwm_req_o;
   logic [31:0] pwm_addr_o;
   logic        pwm_we_o;
   logic [3:0]  pwm_be_o;
   logic [31:0] pwm_wdata_o;
   logic        pwm_rvalid_i;
   logic        irq_o;

   always #5 clk_i = ~clk_i;

   pwm_fade_ctrl dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .device_req_i   (device_req_i),
      .device_addr_i  (device_addr_i),
      .device_we_i    (device_we_i),
      .device_be_i    (device_be_i),
      .device_wdata_i (device_wdata_i),
      .device_rvalid_o(device_rvalid_o),
      .device_rdata_o (device_rdata_o),
      .pwm_req_o      (pwm_req_o),
      .pwm_addr_o     (pwm_addr_o),
      .pwm_we_o       (pwm_we_o),
      .pwm_be_o       (pwm_be_o),
      .pwm_wdata_o    (pwm_wdata_o),
      .pwm_rvalid_i   (pwm_rvalid_i),
      .irq_o          (irq_o)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      else
         n_pass++;
   endtask

   // PWM bank responder: logs writes, answers after rv_lat cycles
   int          cyc = 0;
   int          rv_lat = 1;
   int          pend_cnt = 0;
   bit          pending = 0;
   int          viol = 0;
   logic [31:0] wr_a[$];
   logic [31:0] wr_d[$];
   int          wr_c[$];

   always @(posedge clk_i) cyc++;

   always @(negedge clk_i) begin
      bit old_p;
      old_p = pending;
      pwm_rvalid_i = 1'b0;
      if (rst_i) begin
         pending = 0;
      end else begin
         if (pending) begin
            if (pend_cnt == 0) begin
               pwm_rvalid_i = 1'b1;
               pending = 0;
            end else begin
               pend_cnt--;
            end
         end
         if (pwm_req_o) begin
            if (old_p || pwm_we_o !== 1'b1 || pwm_be_o !== 4'hF) viol++;
            wr_a.push_back(pwm_addr_o);
            wr_d.push_back(pwm_wdata_o);
            wr_c.push_back(cyc);
            pending = 1;
            pend_cnt = rv_lat - 1;
         end
      end
   end

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      @(posedge clk_i); #1;
      device_req_i = 1'b1; device_we_i = 1'b1;
      device_addr_i = a; device_wdata_i = d;
      @(posedge clk_i); #1;
      device_req_i = 1'b0; device_we_i = 1'b0;
   endtask

   task automatic bus_rd(input logic [31:0] a, output logic [31:0] d,
                         output logic v);
      @(posedge clk_i); #1;
      device_req_i = 1'b1; device_we_i = 1'b0;
      device_addr_i = a; device_wdata_i = '0;
      @(posedge clk_i); #1;
      device_req_i = 1'b0;
      d = device_rdata_o;
      v = device_rvalid_o;
   endtask

   task automatic clr_log();
      wr_a.delete(); wr_d.delete(); wr_c.delete();
   endtask

   task automatic run_fade(input logic [31:0] ch, input logic [31:0] lv,
                           input logic [31:0] tm, input logic [31:0] ct);
      bus_wr(32'h04, ch);
      bus_wr(32'h08, lv);
      bus_wr(32'h0C, tm);
      clr_log();
      bus_wr(32'h00, ct);
   endtask

   task automatic wait_idle(input string nm);
      logic [31:0] s;
      logic v;
      s = 32'h1;
      for (int k = 0; k < 600 && s[0]; k++) bus_rd(32'h10, s, v);
      chk({nm, "_idle"}, {31'b0, s[0]}, 32'h0);
   endtask

   task automatic wait_wr(input string nm, input int n);
      for (int k = 0; k < 3000 && wr_d.size() < n; k++) @(negedge clk_i);
      chk({nm, "_nwr"}, 32'(wr_d.size() >= n), 32'h1);
   endtask

   logic [31:0] exp_d[$];

   task automatic check_seq(input string nm, input logic [6:0] idx);
      logic [31:0] ea;
      chk({nm, "_count"}, 32'(wr_d.size()), 32'(exp_d.size()));
      for (int i = 0; i < exp_d.size() && i < wr_d.size(); i++) begin
         ea = {22'b0, idx, (i == 0) ? 3'b100 : 3'b000};
         chk($sformatf("%s_addr%0d", nm, i), wr_a[i], ea);
         chk($sformatf("%s_data%0d", nm, i), wr_d[i], exp_d[i]);
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[14];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        rv;
      logic [31:0] ctrl_exp;

`ifdef PWM_FADE_IRQ_EN
      ctrl_exp = 32'hC;
`else
      ctrl_exp = 32'h4;
`endif
      vt[0]  = '{32'h00, 1'b0, 32'h0, 32'h0};
      vt[1]  = '{32'h04, 1'b0, 32'h0, 32'h0};
      vt[2]  = '{32'h08, 1'b0, 32'h0, 32'h0};
      vt[3]  = '{32'h0C, 1'b0, 32'h0, 32'h0};
      vt[4]  = '{32'h10, 1'b0, 32'h0, 32'h0};
      vt[5]  = '{32'h00, 1'b1, 32'hC, ctrl_exp};
      vt[6]  = '{32'h04, 1'b1, 32'hFFFF_FFFF, 32'h0000_007F};
      vt[7]  = '{32'h08, 1'b1, 32'hFFFF_FFFF, 32'h00FF_FFFF};
      vt[8]  = '{32'h0C, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_00FF};
      vt[9]  = '{32'h10, 1'b1, 32'hFFFF_FFFF, 32'h0};
      vt[10] = '{32'h14, 1'b1, 32'hFFFF_FFFF, 32'h0};
      vt[11] = '{32'h18, 1'b1, 32'hFFFF_FFFF, 32'h0};
      vt[12] = '{32'h1C, 1'b0, 32'h0, 32'h0};
      vt[13] = '{32'h00, 1'b1, 32'h0, 32'h0};

      device_req_i = 0; device_we_i = 0; device_be_i = 4'hF;
      device_addr_i = 0; device_wdata_i = 0; pwm_rvalid_i = 0;
      rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      chk("rst_irq", {31'b0, irq_o}, 32'h0);
      chk("rst_rvalid", {31'b0, device_rvalid_o}, 32'h0);

      repeat (100) @(posedge clk_i);
      chk("idle_no_req", 32'(wr_d.size()), 32'h0);

      for (int i = 0; i < 14; i++) begin
         if (vt[i].we) bus_wr(vt[i].addr, vt[i].wdata);
         bus_rd(vt[i].addr, rd, rv);
         chk($sformatf("vec%0d_rd", i), rd, vt[i].exp);
         chk($sformatf("vec%0d_rv", i), {31'b0, rv}, 32'h1);
      end
      chk("tbl_no_req", 32'(wr_d.size()), 32'h0);

      // Basic up-ramp on channel 5
      run_fade(32'd5, 32'h00FF_4010, 32'h0004_0010, 32'h1);
      wait_idle("up");
      exp_d = '{32'hFF, 32'h10, 32'h20, 32'h30, 32'h40};
      check_seq("up", 7'd5);
      if (wr_c.size() >= 3)
         chk("up_spacing", 32'(wr_c[2] - wr_c[1]), 32'd6);
      bus_rd(32'h10, rd, rv);
      chk("up_status", rd, 32'h2);
      chk("up_irq_off", {31'b0, irq_o}, 32'h0);
      bus_wr(32'h10, 32'h2);
      bus_rd(32'h10, rd, rv);
      chk("up_w1c", rd, 32'h0);

      // Down-ramp that would wrap without saturation
      run_fade(32'd2, 32'h00FF_05F0, 32'h0001_0040, 32'h1);
      wait_idle("dn");
      exp_d = '{32'hFF, 32'hF0, 32'hB0, 32'h70, 32'h30, 32'h05};
      check_seq("dn", 7'd2);

      // Step 0 and dwell 0 both behave as 1
      run_fade(32'd9, 32'h0080_1310, 32'h0, 32'h1);
      wait_idle("s0");
      exp_d = '{32'h80, 32'h10, 32'h11, 32'h12, 32'h13};
      check_seq("s0", 7'd9);
      bus_wr(32'h10, 32'h2);

      // Loop ping-pong, then abort with a slow response
      run_fade(32'd1, 32'h00FF_2000, 32'h0028_0020, 32'h5);
      wait_wr("lp", 5);
      rv_lat = 4;
      repeat (10) @(posedge clk_i);
      bus_wr(32'h10, 32'h2);
      wait_wr("lp6", 6);
      bus_wr(32'h00, 32'h2);
      bus_rd(32'h10, rd, rv);
      chk("ab_busy_hold", {31'b0, rd[0]}, 32'h1);
      wait_idle("ab");
      bus_rd(32'h10, rd, rv);
      chk("ab_status", rd, 32'h0);
      exp_d = '{32'hFF, 32'h00, 32'h20, 32'h00, 32'h20, 32'h00};
      check_seq("lp", 7'd1);
      rv_lat = 1;
      repeat (100) @(posedge clk_i);
      chk("ab_quiet", 32'(wr_d.size()), 32'd6);

      // START while busy and mid-fade rewrites are ignored by the fade
      run_fade(32'd5, 32'h00FF_4010, 32'h0004_0010, 32'h1);
      repeat (5) @(posedge clk_i);
      bus_wr(32'h08, 32'h0011_2233);
      bus_wr(32'h04, 32'd3);
      bus_wr(32'h00, 32'h1);
      wait_idle("sb");
      exp_d = '{32'hFF, 32'h10, 32'h20, 32'h30, 32'h40};
      check_seq("sb", 7'd5);
      bus_rd(32'h08, rd, rv);
      chk("sb_levels_rd", rd, 32'h0011_2233);
      bus_wr(32'h10, 32'h2);

      // ABORT together with START from IDLE: nothing starts
      clr_log();
      bus_wr(32'h00, 32'h3);
      repeat (30) @(posedge clk_i);
      chk("as_no_req", 32'(wr_d.size()), 32'h0);
      bus_rd(32'h10, rd, rv);
      chk("as_status", rd, 32'h0);

      // start == end with the interrupt enable bit set
      run_fade(32'd3, 32'h00FF_3030, 32'h0001_0005, 32'h9);
      wait_idle("eq");
      exp_d = '{32'hFF, 32'h30};
      check_seq("eq", 7'd3);
`ifdef PWM_FADE_IRQ_EN
      chk("irq_set", {31'b0, irq_o}, 32'h1);
`else
      chk("irq_tied", {31'b0, irq_o}, 32'h0);
`endif
      bus_wr(32'h10, 32'h2);
      chk("irq_clr", {31'b0, irq_o}, 32'h0);

      // Reset in the middle of a fade
      run_fade(32'd2, 32'h00FF_8000, 32'h0008_0010, 32'h1);
      repeat (20) @(posedge clk_i);
      #1 rst_i = 1'b1;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      clr_log();
      repeat (50) @(posedge clk_i);
      chk("mr_no_req", 32'(wr_d.size()), 32'h0);
      bus_rd(32'h10, rd, rv);
      chk("mr_status", rd, 32'h0);
      bus_rd(32'h08, rd, rv);
      chk("mr_levels", rd, 32'h0);

      chk("protocol", 32'(viol), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
